shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Parametrised, pipelined shift unit for the execute stage; successor to the single-cycle arithmetic right shifter.
- Supports SLL, SRL, SRA, ROL and ROR on WIDTH-bit operands, with a valid/ready handshake, backpressure, flush and a tag passed through alongside the result.
- The log2(WIDTH)-level barrel network is split across STAGES register stages so the shifter can meet timing at higher clock rates.

Parameters:
- WIDTH, 32, operand/result width; power of two, at least 8.
- STAGES, 2, register stages; legal range 1..SHAMT_W; also the fixed latency.
- TAG_W, 5, width of the sideband tag (e.g. rd index).
- SHAMT_W, $clog2(WIDTH), derived local parameter; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- in_op  in  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved.
- in_a  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount; the caller truncates it (RISC-V semantics).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  shifted value.
- out_tag  out  TAG_W  tag carried with the result.
- out_illegal  out  1  the beat used a reserved op.

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset:
  - All stage valid bits clear.
  - out_valid=0, out_result=0, out_tag=0, out_illegal=0.
  - in_ready=1 once rst_n is high.
  - Reset asserted mid-operation discards every in-flight beat immediately.
- Advance and acceptance:
  - Global-stall pipeline: advance = !out_valid || out_ready.
  - in_ready = advance. A beat is accepted when in_valid && in_ready.
  - When advance=0, every stage holds its data and valid bit. Interior bubbles are not collapsed.
- Latency:
  - A beat accepted at cycle N appears on out_* at N+STAGES, provided advance stays 1.
  - Sustained throughput is one beat per cycle.
  - No combinational path from in_* to out_*. in_ready depends combinationally on out_ready.
- Barrel network:
  - Level k (k=0..SHAMT_W-1) conditionally shifts by 2^k, controlled by shamt[k].
  - Level k sits in stage floor(k*STAGES/SHAMT_W). The output register follows the last level.
  - shamt, op and tag travel with the data through the stages.
- Arithmetic:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the original in_a[WIDTH-1] (sign captured at input and carried).
  - ROL/ROR: bits wrap around.
  - shamt=0 returns in_a unchanged for all modes.
  - Maximum shamt=WIDTH-1: SRA of a negative operand yields all-ones; SRL of it yields 1.
- Reserved op: out_result=in_a, out_illegal=1 for that beat only; the tag still passes through.
- out_illegal and out_tag are valid only while out_valid=1. They hold their last value otherwise.
- Flush:
  - Clears all valid bits on the next edge; data registers need not clear.
  - Takes priority over a simultaneous accept: the beat is dropped even though in_ready=1.
  - flush with out_valid=1 && out_ready=1 in the same cycle: that result counts as delivered this cycle.
- Output stall: out_valid && !out_ready holds out_result/out_tag stable until the handshake completes.

Decomposition:
- Shared package/header shift_pkg:
  - op encodings SH_SLL=3'b000, SH_SRL=3'b001, SH_SRA=3'b010, SH_ROL=3'b011, SH_ROR=3'b100.
  - an is_legal_op function.
- Sub-module shift_level:
  - combinational single level, parameters WIDTH and DIST.
  - inputs: data, enable, mode, fill bit. Output: data.
  - instantiated SHAMT_W times by a generate loop.
- Top level owns the stage registers, valid bits and handshake.

Test Plan:
- Reset then single SRA, WIDTH=32, STAGES=2: in_a=32'h8000_0000, shamt=4, tag=7 -> out_valid exactly 2 cycles later, out_result=32'hF800_0000, out_tag=7, out_illegal=0.
- Back-to-back mixed ops, out_ready=1:
  - beats: SLL 1<<31, SRL 32'hF000_000F>>4, ROR 32'h0000_0001 by 1, ROL 32'h8000_0001 by 1.
  - expected, one per cycle in order: 32'h8000_0000, 32'h0F00_0000, 32'h8000_0000, 32'h0000_0003.
- Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 while stalled, output held stable, no loss or duplication, tags in order.
- Flush:
  - with 2 beats in flight and in_valid=1 in the same cycle -> no out_valid for those 3 beats.
  - next accepted beat emerges with normal latency.
- Reserved op 3'b111 with in_a=32'h1234_5678 -> out_result=32'h1234_5678, out_illegal=1. The following legal beat has out_illegal=0.
- Parameter sweep:
  - WIDTH=16/64, STAGES=1 and STAGES=SHAMT_W.
  - random ops/shamt against a reference model over 10k beats with random out_ready.
  - assert rst_n low mid-stream -> outputs zero asynchronously.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit.
// Contents:
//   SH_SLL..SH_ROR  3-bit operation encodings; codes 3'b101..3'b111 are reserved
//   sh_op_t         operation code type
//   is_legal_op()   1 when an operation code is one of the five defined shifts
package shift_pkg;

    typedef logic [2:0] sh_op_t;

    localparam sh_op_t SH_SLL = 3'b000;
    localparam sh_op_t SH_SRL = 3'b001;
    localparam sh_op_t SH_SRA = 3'b010;
    localparam sh_op_t SH_ROL = 3'b011;
    localparam sh_op_t SH_ROR = 3'b100;

    // The defined codes are contiguous from zero, so one compare covers them.
    function automatic logic is_legal_op(input sh_op_t op);
        return (op <= SH_ROR);
    endfunction

endpackage

// File: rtl/shift_level.sv
// One level of the barrel network: shifts or rotates by a fixed DIST when
// enabled, otherwise passes the data through.
// Ports:
//   din     WIDTH  data entering the level
//   enable  1      this level's shift-amount bit
//   mode    3      operation code (reserved codes pass data through)
//   fill    1      bit shifted in from the MSB side for SRA (original sign)
//   dout    WIDTH  data leaving the level
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             enable,
    input  sh_op_t           mode,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    // Fixed-distance shift/rotate selected by the operation code.
    always_comb begin
        dout = din;
        if (enable) begin
            case (mode)
                SH_SLL:  dout = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SH_SRL:  dout = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
                SH_SRA:  dout = {{DIST{fill}}, din[WIDTH-1:DIST]};
                SH_ROL:  dout = {din[WIDTH-DIST-1:0], din[WIDTH-1:WIDTH-DIST]};
                SH_ROR:  dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
                default: dout = din;
            endcase
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shift unit (SLL, SRL, SRA, ROL, ROR) with valid/ready handshake,
// global-stall backpressure, flush and a sideband tag.
// The log2(WIDTH) barrel levels are spread over STAGES register stages; level k
// lives in stage floor(k*STAGES/SHAMT_W) and the last stage register drives out_*.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         kill every in-flight beat (and any beat offered this cycle)
//   in_valid      input beat valid; in_ready: unit advances this cycle
//   in_op         operation code; in_a: operand; in_shamt: shift amount
//   in_tag        sideband tag carried with the beat
//   out_valid     result valid; out_ready: consumer takes the result
//   out_result    shifted value; out_tag: tag of the beat
//   out_illegal   the beat used a reserved operation code
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STAGES  = 2,
    parameter  int TAG_W   = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);

    logic advance_s;

    // Stage registers; index STAGES-1 is the output register.
    logic               valid_r   [STAGES];
    logic [WIDTH-1:0]   data_r    [STAGES];
    logic [SHAMT_W-1:0] shamt_r   [STAGES];
    sh_op_t             op_r      [STAGES];
    logic               sign_r    [STAGES];
    logic               illegal_r [STAGES];
    logic [TAG_W-1:0]   tag_r     [STAGES];

    // What each stage sees at its input: the port for stage 0, the previous
    // stage register otherwise.
    logic               src_valid_s   [STAGES];
    logic [WIDTH-1:0]   src_data_s    [STAGES];
    logic [SHAMT_W-1:0] src_shamt_s   [STAGES];
    sh_op_t             src_op_s      [STAGES];
    logic               src_sign_s    [STAGES];
    logic               src_illegal_s [STAGES];
    logic [TAG_W-1:0]   src_tag_s     [STAGES];
    logic [WIDTH-1:0]   stage_res_s   [STAGES];

    logic [WIDTH-1:0]   lvl_in_s  [SHAMT_W];
    logic [WIDTH-1:0]   lvl_out_s [SHAMT_W];

    // The whole pipe moves together; it only stops when the output is stuck.
    assign advance_s = !valid_r[STAGES-1] || out_ready;
    assign in_ready  = advance_s;

    assign out_valid   = valid_r[STAGES-1];
    assign out_result  = data_r[STAGES-1];
    assign out_tag     = tag_r[STAGES-1];
    assign out_illegal = illegal_r[STAGES-1];

    // Control fields of the output register have no consumer beyond it.
    logic unused_s;
    assign unused_s = ^{op_r[STAGES-1], shamt_r[STAGES-1], sign_r[STAGES-1]};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_src_in
            assign src_valid_s[s]   = in_valid;
            assign src_data_s[s]    = in_a;
            assign src_shamt_s[s]   = in_shamt;
            assign src_op_s[s]      = in_op;
            // SRA fills with the operand's original sign, captured here.
            assign src_sign_s[s]    = in_a[WIDTH-1];
            assign src_illegal_s[s] = !is_legal_op(in_op);
            assign src_tag_s[s]     = in_tag;
        end else begin : g_src_reg
            assign src_valid_s[s]   = valid_r[s-1];
            assign src_data_s[s]    = data_r[s-1];
            assign src_shamt_s[s]   = shamt_r[s-1];
            assign src_op_s[s]      = op_r[s-1];
            assign src_sign_s[s]    = sign_r[s-1];
            assign src_illegal_s[s] = illegal_r[s-1];
            assign src_tag_s[s]     = tag_r[s-1];
        end

        // Stage register: flush kills valid; payload loads only with a real
        // beat so the output fields hold their last value across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_r[s]   <= 1'b0;
                data_r[s]    <= {WIDTH{1'b0}};
                shamt_r[s]   <= {SHAMT_W{1'b0}};
                op_r[s]      <= SH_SLL;
                sign_r[s]    <= 1'b0;
                illegal_r[s] <= 1'b0;
                tag_r[s]     <= {TAG_W{1'b0}};
            end else if (flush) begin
                valid_r[s] <= 1'b0;
            end else if (advance_s) begin
                valid_r[s] <= src_valid_s[s];
                if (src_valid_s[s]) begin
                    data_r[s]    <= stage_res_s[s];
                    shamt_r[s]   <= src_shamt_s[s];
                    op_r[s]      <= src_op_s[s];
                    sign_r[s]    <= src_sign_s[s];
                    illegal_r[s] <= src_illegal_s[s];
                    tag_r[s]     <= src_tag_s[s];
                end
            end
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
        localparam int ST    = (k * STAGES) / SHAMT_W;
        localparam bit FIRST = (k == 0) || (((k - 1) * STAGES) / SHAMT_W != ST);
        localparam bit LAST  = (k == SHAMT_W - 1) || (((k + 1) * STAGES) / SHAMT_W != ST);

        if (FIRST) begin : g_first
            assign lvl_in_s[k] = src_data_s[ST];
        end else begin : g_chain
            assign lvl_in_s[k] = lvl_out_s[k-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .din    (lvl_in_s[k]),
            .enable (src_shamt_s[ST][k]),
            .mode   (src_op_s[ST]),
            .fill   (src_sign_s[ST]),
            .dout   (lvl_out_s[k])
        );

        if (LAST) begin : g_last
            assign stage_res_s[ST] = lvl_out_s[k];
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int STAGES = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [2:0]  in_op;
    logic [31:0] in_a, out_result;
    logic [4:0]  in_shamt, in_tag, out_tag;

    int chks = 0;
    int errs = 0;

    shift_pipe #(.WIDTH(32), .STAGES(STAGES), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
        .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    // Reference: plain shift arithmetic on a w-bit value held in 64 bits.
    function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] a,
                                              input int sh, input int w);
        logic [63:0] mask, ax, r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        ax = a & mask;
        case (op)
            3'd0: r = ax << sh;
            3'd1: r = ax >> sh;
            3'd2: begin
                if (ax[w-1]) ax = ax | ~mask;
                r = $signed(ax) >>> sh;
            end
            3'd3: r = (sh == 0) ? ax : ((ax << sh) | (ax >> (w - sh)));
            3'd4: r = (sh == 0) ? ax : ((ax >> sh) | (ax << (w - sh)));
            default: r = ax;
        endcase
        return r & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated beat: checks acceptance, exact latency and the result fields.
    task automatic apply_beat(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [4:0] sh, input logic [4:0] tag,
                              input logic [31:0] res, input logic il);
        int cnt;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_op = op; in_a = a; in_shamt = sh; in_tag = tag;
        #1 check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_latency"}, 64'(cnt), 64'(STAGES));
        check({name, "_result"}, 64'(out_result), 64'(res));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        check({name, "_illegal"}, 64'(out_illegal), 64'(il));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        il;
    } vec_t;

    vec_t vecs [14];

    // Randomised sweep over widths and stage counts, one DUT per configuration.
    for (genvar g = 0; g < 5; g++) begin : sw
        localparam int W  = (g < 2) ? 16 : ((g < 4) ? 64 : 32);
        localparam int SW = $clog2(W);
        localparam int S  = (g == 4) ? 2 : ((g % 2 == 0) ? 1 : SW);

        typedef struct packed {
            logic [63:0] r;
            logic [4:0]  t;
            logic        il;
        } exp_t;

        logic          g_rst_n, g_flush, g_iv, g_ir, g_ov, g_or, g_ill;
        logic [2:0]    g_op;
        logic [W-1:0]  g_a, g_res;
        logic [SW-1:0] g_sh;
        logic [4:0]    g_tag, g_otag;
        int errs = 0;
        int chks = 0;
        bit done = 1'b0;
        exp_t q [$];
        exp_t e;

        shift_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(5)) dut (
            .clk(clk), .rst_n(g_rst_n), .flush(g_flush),
            .in_valid(g_iv), .in_ready(g_ir), .in_op(g_op), .in_a(g_a),
            .in_shamt(g_sh), .in_tag(g_tag),
            .out_valid(g_ov), .out_ready(g_or), .out_result(g_res),
            .out_tag(g_otag), .out_illegal(g_ill)
        );

        initial begin
            g_rst_n = 1'b0; g_flush = 1'b0; g_iv = 1'b0; g_or = 1'b0;
            g_op = 3'd0; g_a = '0; g_sh = '0; g_tag = 5'd0;
            repeat (2) @(negedge clk);
            g_rst_n = 1'b1;
            for (int c = 0; c < 3640; c++) begin
                @(negedge clk);
                if (c < 3600) begin
                    g_iv    = ($urandom_range(3) != 0);
                    g_op    = ($urandom_range(15) == 0) ? 3'($urandom_range(7, 5))
                                                        : 3'($urandom_range(4, 0));
                    g_a     = W'({$urandom(), $urandom()});
                    g_sh    = SW'($urandom());
                    g_tag   = 5'($urandom());
                    g_or    = ($urandom_range(3) != 0);
                    g_flush = ($urandom_range(63) == 0);
                end else begin
                    g_iv = 1'b0; g_or = 1'b1; g_flush = 1'b0;
                end
                #1;
                if (g_ov && g_or) begin
                    chks++;
                    if (q.size() == 0) begin
                        errs++;
                        $display("FAIL sweep%0d_spurious: got result 0x%0h tag %0d, expected no beat",
                                 g, g_res, g_otag);
                    end else begin
                        e = q.pop_front();
                        if (g_res !== W'(e.r) || g_otag !== e.t || g_ill !== e.il) begin
                            errs++;
                            $display("FAIL sweep%0d_beat: got 0x%0h/%0d/%0b, expected 0x%0h/%0d/%0b",
                                     g, g_res, g_otag, g_ill, W'(e.r), e.t, e.il);
                        end
                    end
                end
                if (g_flush) begin
                    q.delete();
                end else if (g_iv && g_ir) begin
                    q.push_back('{r: ref_shift(g_op, 64'(g_a), int'(g_sh), W),
                                  t: g_tag, il: (g_op > 3'd4)});
                end
            end
            chks++;
            if (q.size() != 0) begin
                errs++;
                $display("FAIL sweep%0d_drain: got %0d undelivered beats, expected 0", g, q.size());
            end
            done = 1'b1;
        end
    end

    initial begin
        int idx, sent, recv;
        logic stalled_prev;
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        logic [31:0] bb_exp [4];
        logic [2:0]  bb_op [4];
        logic [31:0] bb_a [4];
        logic [4:0]  bb_sh [4];

        vecs[0]  = '{3'b010, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
        vecs[1]  = '{3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[2]  = '{3'b001, 32'hF000_000F, 5'd4,  32'h0F00_0000, 1'b0};
        vecs[3]  = '{3'b100, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0};
        vecs[4]  = '{3'b011, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0};
        vecs[5]  = '{3'b111, 32'h1234_5678, 5'd3,  32'h1234_5678, 1'b1};
        vecs[6]  = '{3'b000, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b0};
        vecs[7]  = '{3'b010, 32'h8765_4321, 5'd0,  32'h8765_4321, 1'b0};
        vecs[8]  = '{3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
        vecs[10] = '{3'b100, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0};
        vecs[11] = '{3'b101, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b1};
        vecs[12] = '{3'b010, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0};
        vecs[13] = '{3'b011, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b0};

        bb_op[0] = 3'b000; bb_a[0] = 32'h0000_0001; bb_sh[0] = 5'd31; bb_exp[0] = 32'h8000_0000;
        bb_op[1] = 3'b001; bb_a[1] = 32'hF000_000F; bb_sh[1] = 5'd4;  bb_exp[1] = 32'h0F00_0000;
        bb_op[2] = 3'b100; bb_a[2] = 32'h0000_0001; bb_sh[2] = 5'd1;  bb_exp[2] = 32'h8000_0000;
        bb_op[3] = 3'b011; bb_a[3] = 32'h8000_0001; bb_sh[3] = 5'd1;  bb_exp[3] = 32'h0000_0003;

        // Reset state.
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_a = 32'd0; in_shamt = 5'd0; in_tag = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single isolated beats from the vector table.
        for (int i = 0; i < 14; i++) begin
            apply_beat($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].sh,
                       5'(i + 7), vecs[i].res, vecs[i].il);
        end

        // Back-to-back mixed ops: one result per cycle, in order.
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 4) begin
                in_valid = 1'b1; in_op = bb_op[c]; in_a = bb_a[c];
                in_shamt = bb_sh[c]; in_tag = 5'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && idx < 4) begin
                check($sformatf("b2b%0d_result", idx), 64'(out_result), 64'(bb_exp[idx]));
                check($sformatf("b2b%0d_tag", idx), 64'(out_tag), 64'(idx + 1));
                check($sformatf("b2b%0d_cycle", idx), 64'(c), 64'(idx + STAGES));
                idx++;
            end
        end
        check("b2b_count", 64'(idx), 64'd4);

        // Backpressure: six beats, output stalled for three cycles mid-stream.
        sent = 0; recv = 0; stalled_prev = 1'b0; held_res = 32'd0; held_tag = 5'd0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c < 7);
            if (sent < 6) begin
                in_valid = 1'b1; in_op = 3'(sent % 5); in_a = 32'hA5C3_0F81 + 32'(sent);
                in_shamt = 5'(3 * sent + 1); in_tag = 5'(10 + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) check("bp_in_ready", 64'(in_ready), 64'd0);
            if (stalled_prev && out_valid) begin
                check("bp_hold_result", 64'(out_result), 64'(held_res));
                check("bp_hold_tag", 64'(out_tag), 64'(held_tag));
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp%0d_tag", recv), 64'(out_tag), 64'(10 + recv));
                check($sformatf("bp%0d_result", recv), 64'(out_result),
                      ref_shift(3'(recv % 5), 64'(32'hA5C3_0F81 + 32'(recv)), 3 * recv + 1, 32));
                recv++;
            end
            stalled_prev = out_valid && !out_ready;
            held_res = out_result;
            held_tag = out_tag;
            if (in_valid && in_ready) sent++;
        end
        check("bp_count", 64'(recv), 64'd6);

        // Flush: beat 20 delivered in the flush cycle, beats 21/22 killed.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = SH_SLL; in_a = 32'h0000_00FF;
            in_shamt = 5'd4; in_tag = 5'(20 + c);
            flush = (c == 2);
        end
        #1;
        check("flush_deliver_valid", 64'(out_valid), 64'd1);
        check("flush_deliver_tag", 64'(out_tag), 64'd20);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b0;
            #1 check($sformatf("flush_quiet%0d", c), 64'(out_valid), 64'd0);
        end
        apply_beat("post_flush", SH_SRA, 32'hF000_0000, 5'd8, 5'd23, 32'hFFF0_0000, 1'b0);

        // Asynchronous reset in the middle of a stream.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_op = SH_SLL;
            in_a = 32'hFFFF_FFFF; in_shamt = 5'd1; in_tag = 5'(25 + c);
        end
        #2;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_tag", 64'(out_tag), 64'd26);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", 64'(out_result), 64'd0);
        check("async_rst_tag", 64'(out_tag), 64'd0);
        check("async_rst_illegal", 64'(out_illegal), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_quiet", 64'(out_valid), 64'd0);
        apply_beat("post_rst", SH_ROR, 32'h0000_00F1, 5'd4, 5'd30, 32'h1000_000F, 1'b0);

        // Collect the randomised sweep results.
        for (int t = 0; t < 20000; t++) begin
            if (sw[0].done && sw[1].done && sw[2].done && sw[3].done && sw[4].done) break;
            @(negedge clk);
        end
        check("sweep_done", 64'({sw[0].done, sw[1].done, sw[2].done, sw[3].done, sw[4].done}),
              64'(5'b11111));
        errs += sw[0].errs + sw[1].errs + sw[2].errs + sw[3].errs + sw[4].errs;
        chks += sw[0].chks + sw[1].chks + sw[2].chks + sw[3].chks + sw[4].chks;

        $display("Simulation finished: %0d checks, %0d errors", chks, errs);
        $finish;
    end

endmodule
